uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 28 ++
 rtl/uart_tx_fifo_if.sv | 37 +++
 rtl/uart_tx_fifo_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
//   Shared definitions for the serial transmit path: drain FSM state
//   encoding, the serial-port address constants used by the MEM stage,
//   and a helper for the occupancy counter width.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_SETUP     = 3'd2,
    ST_STROBE    = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT_TBRE = 3'd5,
    ST_WAIT_TSRE = 3'd6
  } utx_state_t;

  // Serial-port addresses decoded by the MEM stage.
  localparam logic [15:0] SERIAL_DATA_ADDR  = 16'hBF00;
  localparam logic [15:0] SERIAL_STATE_ADDR = 16'hBF01;
  // Bit of the state word that carries the writeable flag.
  localparam int unsigned SERIAL_WRITEABLE_BIT = 0;

  // Occupancy needs one more bit than the pointers so DEPTH itself fits.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Groups the MEM-stage write port, queue status and the UART chip / ram1
//   bus handshake of uart_tx_fifo.
//   slave  : the transmit queue (samples utxi_*, drives utxo_*)
//   master : the surrounding MEM stage / board (drives utxi_*, samples utxo_*)
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) ();

  logic                            utxi_wrn;
  logic [15:0]                     utxi_data;
  logic                            utxo_writeable;
  logic [count_width(DEPTH)-1:0]   utxo_count;
  logic                            utxo_overflow;
  logic                            utxo_bus_req;
  logic                            utxi_bus_busy;
  logic                            utxo_data_oe;
  logic [7:0]                      utxo_uart_data;
  logic                            utxo_uart_wrn;
  logic                            utxi_uart_tbre;
  logic                            utxi_uart_tsre;

  modport slave (
    input  utxi_wrn, utxi_data, utxi_bus_busy, utxi_uart_tbre, utxi_uart_tsre,
    output utxo_writeable, utxo_count, utxo_overflow, utxo_bus_req,
           utxo_data_oe, utxo_uart_data, utxo_uart_wrn
  );

  modport master (
    output utxi_wrn, utxi_data, utxi_bus_busy, utxi_uart_tbre, utxi_uart_tsre,
    input  utxo_writeable, utxo_count, utxo_overflow, utxo_bus_req,
           utxo_data_oe, utxo_uart_data, utxo_uart_wrn
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo
//   Circular-buffer FIFO with a separate occupancy counter so full and empty
//   are unambiguous. A push while full is accepted only when a pop happens in
//   the same cycle (the pop frees the slot first).
//   clk, rst_n   : clock, synchronous active-low reset
//   push, wdata  : write request and data
//   pop, rdata   : read request; rdata shows the head entry combinationally
//   count        : occupancy 0..DEPTH
//   full, empty  : derived from count
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        tail <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte-wide transmit queue between the MEM stage and the external UART.
//   MEM-stage writes are edge-detected so a stalled store pushes once; bytes
//   are drained to the UART with the wrn/tbre/tsre handshake after the ram1
//   data bus has been granted.
//   utxi_clk, utxi_rst : clock, synchronous active-low reset
//   utx (slave)        : MEM write port, queue status, bus request/grant,
//                        UART data/strobe/status
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WR_PULSE = 4
) (
  input  logic          utxi_clk,
  input  logic          utxi_rst,
  uart_tx_fifo_if.slave utx
);

  localparam int unsigned CW = count_width(DEPTH);
  localparam int unsigned PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  logic          wrn_hist;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [7:0]    unused_data_hi;

  utx_state_t    state;
  logic [PW-1:0] pulse_cnt;
  logic          overflow;
  logic          bus_req;
  logic          data_oe;
  logic          uart_wrn;
  logic [7:0]    uart_data;

  assign unused_data_hi = utx.utxi_data[15:8];

  // One push per falling edge of the request, however long it stays low.
  assign push = wrn_hist && !utx.utxi_wrn;
  assign pop  = (state == ST_REQ) && !utx.utxi_bus_busy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (utxi_clk),
    .rst_n (utxi_rst),
    .push  (push),
    .wdata (utx.utxi_data[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge utxi_clk) begin
    if (!utxi_rst) begin
      wrn_hist <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wrn_hist <= utx.utxi_wrn;
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Outputs are registered alongside the state, so each is loaded on the
  // transition into the state where it must hold its new value.
  always_ff @(posedge utxi_clk) begin
    if (!utxi_rst) begin
      state     <= ST_IDLE;
      pulse_cnt <= '0;
      bus_req   <= 1'b0;
      data_oe   <= 1'b0;
      uart_wrn  <= 1'b1;
      uart_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state   <= ST_REQ;
            bus_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!utx.utxi_bus_busy) begin
            state     <= ST_SETUP;
            uart_data <= fifo_rdata;
            data_oe   <= 1'b1;
          end
        end
        ST_SETUP: begin
          state     <= ST_STROBE;
          uart_wrn  <= 1'b0;
          pulse_cnt <= PW'(WR_PULSE - 1);
        end
        ST_STROBE: begin
          if (pulse_cnt == '0) begin
            state    <= ST_HOLD;
            uart_wrn <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          state   <= ST_WAIT_TBRE;
          data_oe <= 1'b0;
          bus_req <= 1'b0;
        end
        ST_WAIT_TBRE: begin
          if (utx.utxi_uart_tbre) begin
            state <= ST_WAIT_TSRE;
          end
        end
        ST_WAIT_TSRE: begin
          if (utx.utxi_uart_tsre) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus_req  <= 1'b0;
          data_oe  <= 1'b0;
          uart_wrn <= 1'b1;
        end
      endcase
    end
  end

  assign utx.utxo_writeable = !fifo_full;
  assign utx.utxo_count     = fifo_count;
  assign utx.utxo_overflow  = overflow;
  assign utx.utxo_bus_req   = bus_req;
  assign utx.utxo_data_oe   = data_oe;
  assign utx.utxo_uart_data = uart_data;
  assign utx.utxo_uart_wrn  = uart_wrn;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned WR_PULSE = 4;

  logic clk;
  logic rst;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) utx ();

  uart_tx_fifo #(
    .DEPTH    (DEPTH),
    .WR_PULSE (WR_PULSE)
  ) dut (
    .utxi_clk (clk),
    .utxi_rst (rst),
    .utx      (utx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  byte unsigned got[$];
  byte unsigned exp_q[$];
  byte unsigned model[$];
  bit           rnd_hs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART-side observer: a byte is written when wrn returns high; the strobe
  // length, data stability and bus ownership are checked along the way.
  logic       mon_prev_wrn = 1'b1;
  int         mon_len = 0;
  logic [7:0] mon_cap = '0;

  always @(negedge clk) begin
    if (utx.utxo_uart_wrn === 1'b0) begin
      if (mon_prev_wrn) begin
        mon_len = 1;
        mon_cap = utx.utxo_uart_data;
      end else begin
        mon_len++;
        chk("data_stable", 32'(utx.utxo_uart_data), 32'(mon_cap));
      end
      chk("oe_in_strobe", 32'(utx.utxo_data_oe), 32'd1);
      chk("req_in_strobe", 32'(utx.utxo_bus_req), 32'd1);
    end else if (!mon_prev_wrn && rst === 1'b1) begin
      chk("pulse_len", 32'(mon_len), 32'(WR_PULSE));
      got.push_back(mon_cap);
    end
    mon_prev_wrn = (utx.utxo_uart_wrn !== 1'b0);
  end

  task automatic do_reset();
    utx.utxi_wrn = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got.delete();
  endtask

  task automatic push_byte(input logic [15:0] d);
    @(negedge clk);
    utx.utxi_wrn  = 1'b0;
    utx.utxi_data = d;
    @(negedge clk);
    utx.utxi_wrn  = 1'b1;
  endtask

  task automatic drain_check(input string tag);
    int unsigned k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rnd_hs) begin
        utx.utxi_bus_busy  = 1'($urandom_range(0, 1));
        utx.utxi_uart_tbre = 1'($urandom_range(0, 1));
        utx.utxi_uart_tsre = 1'($urandom_range(0, 1));
      end
      if (got.size() >= exp_q.size() && utx.utxo_bus_req === 1'b0 && utx.utxo_count === '0)
        break;
    end
    chk({tag, "_drain_done"}, 32'(k < 3000), 32'd1);
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i),
          (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic prev;
    logic nw;
    logic [15:0] d;
    int unsigned n;

    rst                = 1'b0;
    utx.utxi_wrn       = 1'b1;
    utx.utxi_data      = '0;
    utx.utxi_bus_busy  = 1'b0;
    utx.utxi_uart_tbre = 1'b1;
    utx.utxi_uart_tsre = 1'b1;

    // Reset values
    do_reset();
    chk("rst_count", 32'(utx.utxo_count), 32'd0);
    chk("rst_overflow", 32'(utx.utxo_overflow), 32'd0);
    chk("rst_writeable", 32'(utx.utxo_writeable), 32'd1);
    chk("rst_bus_req", 32'(utx.utxo_bus_req), 32'd0);
    chk("rst_data_oe", 32'(utx.utxo_data_oe), 32'd0);
    chk("rst_uart_wrn", 32'(utx.utxo_uart_wrn), 32'd1);
    chk("rst_uart_data", 32'(utx.utxo_uart_data), 32'd0);

    // Single write of 0x0041: strobe 3 edges after the push
    @(negedge clk);
    utx.utxi_wrn  = 1'b0;
    utx.utxi_data = 16'h0041;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      utx.utxi_wrn = 1'b1;
      if (k == 1) chk("t1_count_after_push", 32'(utx.utxo_count), 32'd1);
      if (utx.utxo_uart_wrn === 1'b0) begin
        lat = k - 1;
        break;
      end
    end
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_strobe_data", 32'(utx.utxo_uart_data), 32'h41);
    chk("t1_count_in_strobe", 32'(utx.utxo_count), 32'd0);
    exp_q = '{8'h41};
    drain_check("t1");

    // Request held low 10 cycles: one push only
    do_reset();
    utx.utxi_bus_busy = 1'b1;
    @(negedge clk);
    utx.utxi_wrn  = 1'b0;
    utx.utxi_data = 16'h0055;
    repeat (10) @(negedge clk);
    utx.utxi_wrn = 1'b1;
    @(negedge clk);
    chk("t2_count", 32'(utx.utxo_count), 32'd1);
    utx.utxi_bus_busy = 1'b0;
    exp_q = '{8'h55};
    drain_check("t2");

    // Nine pushes into an 8-deep queue
    do_reset();
    utx.utxi_bus_busy  = 1'b1;
    utx.utxi_uart_tbre = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push_byte(16'(i));
      if (i == 8) begin
        chk("t3_count_at_8", 32'(utx.utxo_count), 32'd8);
        chk("t3_ovf_at_8", 32'(utx.utxo_overflow), 32'd0);
      end
    end
    @(negedge clk);
    chk("t3_count_sat", 32'(utx.utxo_count), 32'd8);
    chk("t3_overflow", 32'(utx.utxo_overflow), 32'd1);
    chk("t3_writeable", 32'(utx.utxo_writeable), 32'd0);
    utx.utxi_bus_busy = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_count_tbre_low", 32'(utx.utxo_count), 32'd7);
    chk("t3_one_sent", 32'(got.size()), 32'd1);
    utx.utxi_uart_tbre = 1'b1;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    drain_check("t3");

    // Push into a full queue in the cycle REQ pops
    do_reset();
    utx.utxi_bus_busy = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(16'(8'h10 + i));
    chk("t4_count_full", 32'(utx.utxo_count), 32'd8);
    @(negedge clk);
    utx.utxi_bus_busy = 1'b0;
    utx.utxi_wrn      = 1'b0;
    utx.utxi_data     = 16'h0018;
    @(negedge clk);
    utx.utxi_wrn = 1'b1;
    chk("t4_count", 32'(utx.utxo_count), 32'd8);
    chk("t4_overflow", 32'(utx.utxo_overflow), 32'd0);
    chk("t4_writeable", 32'(utx.utxo_writeable), 32'd0);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    drain_check("t4");

    // Bus busy for 20 cycles with two bytes queued
    do_reset();
    utx.utxi_bus_busy = 1'b1;
    push_byte(16'h00A1);
    push_byte(16'h00A2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_bus_req", 32'(utx.utxo_bus_req), 32'd1);
      chk("t5_oe", 32'(utx.utxo_data_oe), 32'd0);
      chk("t5_wrn", 32'(utx.utxo_uart_wrn), 32'd1);
      chk("t5_count", 32'(utx.utxo_count), 32'd2);
    end
    utx.utxi_bus_busy = 1'b0;
    @(negedge clk);
    chk("t5_oe_after_grant", 32'(utx.utxo_data_oe), 32'd1);
    chk("t5_count_after_grant", 32'(utx.utxo_count), 32'd1);
    chk("t5_data_after_grant", 32'(utx.utxo_uart_data), 32'hA1);
    exp_q = '{8'hA1, 8'hA2};
    drain_check("t5");

    // Reset during STROBE discards everything
    do_reset();
    utx.utxi_bus_busy = 1'b1;
    push_byte(16'h00C1);
    push_byte(16'h00C2);
    push_byte(16'h00C3);
    utx.utxi_bus_busy = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (utx.utxo_uart_wrn === 1'b0) begin
        lat = k;
        break;
      end
    end
    chk("t6_strobe_seen", 32'(lat > 0), 32'd1);
    chk("t6_count_in_strobe", 32'(utx.utxo_count), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_wrn", 32'(utx.utxo_uart_wrn), 32'd1);
    chk("t6_oe", 32'(utx.utxo_data_oe), 32'd0);
    chk("t6_count", 32'(utx.utxo_count), 32'd0);
    chk("t6_bus_req", 32'(utx.utxo_bus_req), 32'd0);
    chk("t6_writeable", 32'(utx.utxo_writeable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_idle_req", 32'(utx.utxo_bus_req), 32'd0);
    chk("t6_idle_count", 32'(utx.utxo_count), 32'd0);
    chk("t6_nothing_sent", 32'(got.size()), 32'd0);

    // Randomized bursts against a queue model, bus held so nothing pops
    for (int r = 0; r < 8; r++) begin
      bit m_ovf;
      do_reset();
      utx.utxi_bus_busy  = 1'b1;
      utx.utxi_uart_tbre = 1'b0;
      utx.utxi_uart_tsre = 1'b0;
      model.delete();
      m_ovf = 1'b0;
      prev  = 1'b1;
      n = $urandom_range(20, 40);
      for (int c = 0; c <= n; c++) begin
        @(negedge clk);
        chk("rnd_count", 32'(utx.utxo_count), 32'(model.size()));
        chk("rnd_writeable", 32'(utx.utxo_writeable), 32'(model.size() < DEPTH));
        chk("rnd_overflow", 32'(utx.utxo_overflow), 32'(m_ovf));
        nw = (c == n) ? 1'b1 : 1'($urandom_range(0, 1));
        d  = 16'($urandom);
        utx.utxi_wrn  = nw;
        utx.utxi_data = d;
        if (prev && !nw) begin
          if (model.size() < DEPTH) model.push_back(d[7:0]);
          else m_ovf = 1'b1;
        end
        prev = nw;
      end
      exp_q  = model;
      rnd_hs = 1'b1;
      drain_check("rnd");
      rnd_hs = 1'b0;
      chk("rnd_overflow_sticky", 32'(utx.utxo_overflow), 32'(m_ovf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
